// File: rtl/stream_mux_rr_pkg.sv
// ----------------------------------------------------------------------------
// stream_mux_pkg
// Shared types and helpers for the stream_mux_rr multiplexer.
//   mux_mode_e     : channel choice policy (explicit select or round-robin)
//   N_CH_DEFAULT   : default channel count
//   DATA_W_DEFAULT : default payload width
//   next_ptr()     : increment with wrap-around for any channel count
// ----------------------------------------------------------------------------
package stream_mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    localparam int N_CH_DEFAULT   = 4;
    localparam int DATA_W_DEFAULT = 8;

    // Compare-and-clear instead of a modulo so non-power-of-2 counts wrap
    // correctly without a divider.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Grants the first requester found
// searching upward from ptr, wrapping N_CH-1 -> 0.
//   req       [N_CH-1:0]  : request vector
//   ptr       [IDX_W-1:0] : highest-priority index (kept in range by owner)
//   grant     [N_CH-1:0]  : one-hot grant, all-zero when nothing requests
//   grant_idx [IDX_W-1:0] : binary index of the grant (0 when no grant)
// ----------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cur;

    // Walk the candidate index from ptr for N_CH steps; the inner loop turns
    // the variable candidate into constant bit selects on req/grant.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the unassigned paths infer latches.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cur       = ptr;
        for (int k = 0; k < N_CH; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!found && req[i] && (32'(cur) == 32'(i))) begin
                    grant[i]  = 1'b1;
                    grant_idx = cur;
                    found     = 1'b1;
                end
            end
            cur = IDX_W'(next_ptr(32'(cur), N_CH));
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// ----------------------------------------------------------------------------
// stream_mux_rr
// N-channel valid/ready stream multiplexer with a single registered output
// stage. Channel choice is explicit (sel) or round-robin (mode=1). The output
// register reloads in the same cycle it is drained, so throughput is one beat
// per cycle while the consumer is ready.
//
// Ports:
//   clk, rst_n                : rising-edge clock, async active-low reset
//   mode                      : 0 = explicit select, 1 = round-robin
//   sel       [SEL_W-1:0]     : channel used when mode=0 (>= N_CH: none)
//   in_valid  [N_CH-1:0]      : per-channel valid
//   in_data   [N_CH*DATA_W-1:0]: channel i at [i*DATA_W +: DATA_W]
//   in_ready  [N_CH-1:0]      : per-channel ready (at most one high)
//   out_valid, out_data, out_ch: registered output beat and its source
//   out_ready                 : consumer ready
//
// Optional build macro STREAM_MUX_PKT_LOCK_EN adds in_last/out_last: after a
// non-last beat the grant stays locked to that channel until its last beat,
// and the round-robin pointer only advances on last beats.
// ----------------------------------------------------------------------------
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = N_CH_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic [N_CH-1:0]        in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    input  logic                   out_ready
`ifdef STREAM_MUX_PKT_LOCK_EN
    ,
    input  logic [N_CH-1:0]        in_last,
    output logic                   out_last
`endif
);

    mux_mode_e         mode_e;
    logic [SEL_W-1:0]  rr_ptr;
    logic              load_en;
    logic              xfer;
    logic              beat_last;
    logic [N_CH-1:0]   rr_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic [N_CH-1:0]   grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_data;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic              lock_active;
    logic [SEL_W-1:0]  lock_ch;
`endif

    assign mode_e  = mux_mode_e'(mode);
    assign load_en = !out_valid || out_ready;

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_active) begin
            // Mid-packet: only the locked channel may send, whatever mode/sel say.
            for (int i = 0; i < N_CH; i++) begin
                grant[i] = in_valid[i] && (32'(lock_ch) == 32'(i));
            end
            grant_idx = lock_ch;
        end else
`endif
        if (mode_e == MODE_RR) begin
            grant     = rr_grant;
            grant_idx = rr_idx;
        end else begin
            // Out-of-range sel matches no channel, so nothing is granted.
            for (int i = 0; i < N_CH; i++) begin
                grant[i] = in_valid[i] && (32'(sel) == 32'(i));
            end
            grant_idx = sel;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) grant_data = in_data[i*DATA_W +: DATA_W];
        end
    end

    assign in_ready = load_en ? grant : '0;
    assign xfer     = |in_ready;

`ifdef STREAM_MUX_PKT_LOCK_EN
    assign beat_last = |(in_last & grant);
`else
    assign beat_last = 1'b1;
`endif

    // NOTE: sequential state is assigned only with non-blocking (<=) so all
    // registers update from pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ch      <= '0;
            rr_ptr      <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last    <= 1'b0;
            lock_active <= 1'b0;
            lock_ch     <= '0;
`endif
        end else begin
            if (xfer) begin
                // Covers both an empty register and a same-cycle drain+reload.
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                if (mode_e == MODE_RR && beat_last) begin
                    rr_ptr <= SEL_W'(next_ptr(32'(grant_idx), N_CH));
                end
`ifdef STREAM_MUX_PKT_LOCK_EN
                out_last    <= beat_last;
                lock_active <= !beat_last;
                lock_ch     <= grant_idx;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// ----------------------------------------------------------------------------
// tb_stream_mux_rr
// Drives a 4-channel and a 3-channel instance from one shared stimulus and
// compares both against a behavioural model: grant = first valid channel at or
// after the pointer (modular arithmetic), a one-entry output register, and
// (with STREAM_MUX_PKT_LOCK_EN) a packet lock.
// ----------------------------------------------------------------------------
module tb_stream_mux_rr;

`ifdef STREAM_MUX_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic [3:0]  valid_in = '0;
    logic [3:0]  last_in = '0;
    logic [31:0] data4 = '0;
    logic        ordy = 1'b0;

    logic [3:0]  rdy4;
    logic        ov4;
    logic [7:0]  od4;
    logic [1:0]  och4;
    logic [2:0]  rdy3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  och3;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic        ol4;
    logic        ol3;
`endif

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(4), .DATA_W(8)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (valid_in),
        .in_data   (data4),
        .in_ready  (rdy4),
        .out_valid (ov4),
        .out_data  (od4),
        .out_ch    (och4),
        .out_ready (ordy)
`ifdef STREAM_MUX_PKT_LOCK_EN
        ,
        .in_last   (last_in),
        .out_last  (ol4)
`endif
    );

    stream_mux_rr #(.N_CH(3), .DATA_W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (valid_in[2:0]),
        .in_data   (data4[23:0]),
        .in_ready  (rdy3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_ch    (och3),
        .out_ready (ordy)
`ifdef STREAM_MUX_PKT_LOCK_EN
        ,
        .in_last   (last_in[2:0]),
        .out_last  (ol3)
`endif
    );

    // Reference model state, index 0 = 4-channel, index 1 = 3-channel.
    bit         m_ov  [2];
    logic [7:0] m_od  [2];
    int         m_och [2];
    int         m_rr  [2];
    bit         m_lk  [2];
    int         m_lch [2];
    bit         m_ol  [2];
    int         g     [2];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic bit vbit(input int c);
        return ((valid_in >> c) & 4'd1) != 4'd0;
    endfunction

    function automatic bit lbit(input int c);
        return ((last_in >> c) & 4'd1) != 4'd0;
    endfunction

    // Channel the model expects to be accepted this cycle, -1 for none.
    function automatic int grant_of(input int d);
        int n;
        int s;
        n = nch(d);
        s = 32'(sel);
        if (m_ov[d] && !ordy) return -1;
        if (m_lk[d]) return vbit(m_lch[d]) ? m_lch[d] : -1;
        if (!mode) return (s < n && vbit(s)) ? s : -1;
        for (int k = 0; k < n; k++) begin
            if (vbit((m_rr[d] + k) % n)) return (m_rr[d] + k) % n;
        end
        return -1;
    endfunction

    function automatic int exp_rdy(input int d);
        return (g[d] < 0) ? 0 : (1 << g[d]);
    endfunction

    task automatic model_update(input int d);
        int  gg;
        bit  is_last;
        gg = g[d];
        if (gg >= 0) begin
            is_last  = LOCK ? lbit(gg) : 1'b1;
            m_ov[d]  = 1'b1;
            m_od[d]  = 8'(data4 >> (8 * gg));
            m_och[d] = gg;
            m_ol[d]  = LOCK && is_last;
            m_lk[d]  = LOCK && !is_last;
            m_lch[d] = gg;
            if (mode && is_last) m_rr[d] = (gg + 1) % nch(d);
        end else if (ordy) begin
            m_ov[d] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ov[d] = 1'b0; m_od[d] = '0; m_och[d] = 0; m_rr[d] = 0;
            m_lk[d] = 1'b0; m_lch[d] = 0; m_ol[d] = 1'b0; g[d] = -1;
        end
    endtask

    task automatic check_outputs();
        check("out_valid4", 32'(ov4), 32'(m_ov[0]));
        check("out_valid3", 32'(ov3), 32'(m_ov[1]));
        if (m_ov[0]) begin
            check("out_data4", 32'(od4), 32'(m_od[0]));
            check("out_ch4", 32'(och4), 32'(m_och[0]));
        end
        if (m_ov[1]) begin
            check("out_data3", 32'(od3), 32'(m_od[1]));
            check("out_ch3", 32'(och3), 32'(m_och[1]));
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        check("out_last4", 32'(ol4), 32'(m_ol[0]));
        check("out_last3", 32'(ol3), 32'(m_ol[1]));
`endif
    endtask

    // Called at posedge+1 with inputs already applied: checks in_ready
    // mid-cycle, then the registered outputs just after the next edge.
    task automatic step();
        #2;
        for (int d = 0; d < 2; d++) g[d] = grant_of(d);
        check("in_ready4", 32'(rdy4), 32'(exp_rdy(0)));
        check("in_ready3", 32'(rdy3), 32'(exp_rdy(1)));
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
        mode = m; sel = s; valid_in = v; ordy = r;
    endtask

    initial begin
        model_reset();

        // Reset state.
        @(posedge clk); #1;
        check("rst_out_valid4", 32'(ov4), 32'd0);
        check("rst_out_data4", 32'(od4), 32'd0);
        check("rst_out_ch4", 32'(och4), 32'd0);
        check("rst_in_ready4", 32'(rdy4), 32'd0);
        check("rst_out_valid3", 32'(ov3), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: explicit select of channel 2.
        data4 = 32'h00A5_0000;
        drive(1'b0, 2'd2, 4'b0100, 1'b1);
        #2;
        check("sel2_in_ready", 32'(rdy4), 32'h4);
        @(posedge clk); #1;
        check("sel2_out_valid", 32'(ov4), 32'd1);
        check("sel2_out_data", 32'(od4), 32'hA5);
        check("sel2_out_ch", 32'(och4), 32'd2);
        g[0] = 2; g[1] = 2;
        model_update(0); model_update(1);
        drive(1'b0, 2'd2, 4'b0000, 1'b1);
        step();

        // 2: round-robin over all channels, no bubbles.
        data4 = 32'h0302_0100;
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_seq4", 32'(och4), 32'(k % 4));
            check("rr_seq3", 32'(och3), 32'(k % 3));
            check("rr_nobubble", 32'(ov4), 32'd1);
        end

        // 3: only channels 1 and 3 requesting.
        drive(1'b1, 2'd0, 4'b1010, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_alt4", 32'(och4), (k % 2 == 0) ? 32'd1 : 32'd3);
        end

        // 4: stall for three cycles while inputs churn, then release.
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        data4 = $urandom;
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 1'b0);
            data4 = $urandom;
            step();
            check("stall_ready4", 32'(rdy4), 32'd0);
        end
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        step();
        step();

        // 5: sel beyond the 3-channel range, then async reset mid-stream.
        drive(1'b0, 2'd3, 4'b1111, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("sel_oob_ready3", 32'(rdy3), 32'd0);
        end
        drive(1'b1, 2'd0, 4'b0010, 1'b1);
        step();
        drive(1'b1, 2'd0, 4'b1111, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ov4", 32'(ov4), 32'd0);
        check("async_rst_ov3", 32'(ov3), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        step();
        check("rst_ptr4", 32'(och4), 32'd0);
        check("rst_ptr3", 32'(och3), 32'd0);

`ifdef STREAM_MUX_PKT_LOCK_EN
        // 6: three-beat packet on channel 0 holds off channel 1.
        last_in = 4'b1111;
        drive(1'b1, 2'd0, 4'b1000, 1'b1);
        step();
        drive(1'b1, 2'd0, 4'b0011, 1'b1);
        for (int k = 0; k < 4; k++) begin
            last_in = (k == 2) ? 4'b0001 : 4'b0000;
            if (k == 3) last_in = 4'b1111;
            step();
            check("pkt_ch", 32'(och4), (k < 3) ? 32'd0 : 32'd1);
            check("pkt_last", 32'(ol4), (k == 2) ? 32'd1 : 32'd0);
        end
        last_in = 4'b1111;
        step();
`endif

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom),
                  $urandom_range(0, 9) < 7);
            data4   = $urandom;
            last_in = 4'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel, W-bit stream multiplexer with valid/ready handshake and a registered output stage. It is the clocked, multi-channel successor to the team's plain 2:1 mux. Channel choice is either explicit (select input) or round-robin arbitration. It sits between several producer streams and a single consumer.

Parameters:
- N_CH, 4: number of input channels; must be ≥ 2.
- DATA_W, 8: payload width in bits.
- SEL_W, $clog2(N_CH): width of sel and out_ch (derived).

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- mode, input, 1: 0 = explicit select, 1 = round-robin.
- sel, input, SEL_W: channel index used when mode=0.
- in_valid, input, N_CH: per-channel valid.
- in_data, input, N_CH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready, output, N_CH: per-channel ready.
- out_valid, output, 1: output register holds data.
- out_data, output, DATA_W: registered payload.
- out_ch, output, SEL_W: source channel of out_data.
- out_ready, input, 1: consumer ready.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is combinational and therefore all 0 while out_valid=0 and no grant exists.
- load_en = !out_valid || out_ready. This gives single-stage full throughput: one transfer per cycle when the consumer is always ready.
- Grant, mode=0:
  - grant[sel] = in_valid[sel].
  - sel ≥ N_CH gives no grant; all in_ready=0.
- Grant, mode=1:
  - First channel with in_valid=1, searching upward from rr_ptr and wrapping N_CH-1 → 0.
- in_ready[i] = load_en && grant[i]. At most one in_ready is high per cycle.
- Input transfer on channel i: in_valid[i] && in_ready[i]. On the next edge: out_data ← channel i data, out_ch ← i, out_valid ← 1.
- Output transfer: out_valid && out_ready. If no new grant in the same cycle, out_valid ← 0 next edge.
- Simultaneous output transfer and new grant: register reloads, out_valid stays 1. No bubble.
- rr_ptr:
  - Updates only on an input transfer in mode=1: rr_ptr ← (granted+1) mod N_CH. Handles non-power-of-2 N_CH.
  - Held in mode=0 and when no transfer occurs.
- Latency: input transfer to out_valid is 1 cycle.
- Stall (out_valid=1, out_ready=0): out_data and out_ch stay stable; all in_ready=0.
- Mode or sel change while stalled: the held output is unaffected. The new mode/sel applies at the next load_en cycle.
- No valid inputs while load_en=1: out_valid falls after the pending output transfer. Nothing is granted.
- Reset mid-transfer: the held output is discarded and all state returns to reset values immediately.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Adds input in_last[N_CH] and output out_last (registered alongside out_data; reset 0).
  - After a transfer with in_last[i]=0, the grant locks to channel i, overriding mode and sel, until a transfer with in_last[i]=1.
  - Lock flag resets to 0 asynchronously.
  - rr_ptr advances only on the last beat.
- Undefined: no in_last/out_last ports; every beat is arbitrated independently.

Decomposition:
- Package stream_mux_pkg:
  - typedef enum logic {MODE_SEL=1'b0, MODE_RR=1'b1} mux_mode_e;
  - localparam default N_CH/DATA_W constants;
  - function next_ptr(idx, n) for the wrap-around.
- Sub-module rr_arbiter (params N_CH): inputs req, ptr; outputs one-hot grant and binary grant index. Purely combinational. Instantiated once; the pointer register stays in the top.

Test Plan:
1. Reset, then mode=0, sel=2, in_valid=4'b0100, channel-2 data=8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
2. Mode=1, all in_valid=1, data = channel index, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3 with no bubbles.
3. Mode=1, only channels 1 and 3 valid → alternates 1,3,1,3. Then N_CH=3 build with all valid → 0,1,2,0 (wrap check).
4. out_valid=1, out_ready=0 for 3 cycles while inputs change → out_data/out_ch stable, in_ready=0. Release → held word accepted, then next grant loaded the following cycle.
5. mode=0, sel=3 with N_CH=3 build, all valid → no in_ready ever. Assert rst_n=0 mid-stream → out_valid=0 immediately (asynchronous), rr_ptr=0.
6. With STREAM_MUX_PKT_LOCK_EN, mode=1, channel 0 sends 3-beat packet (last on beat 3) while channel 1 valid → out_ch=0,0,0 then 1; out_last=1 only on third beat.
